// File: rtl/pivot_rom_cache.sv
// Direct-mapped read-only line cache: 16-bit toggle-handshake client port in front of
// a 64-bit toggle-handshake SDRAM burst channel. Hits answer two clocks after the request.
module pivot_rom_cache #(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] client_addr,
    input  logic              client_req,
    output logic [15:0]       client_data,
    output logic              client_ack,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic              sdr_req,
    input  logic              sdr_ack,
    input  logic [63:0]       sdr_data,
    output logic              busy
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - 3 - IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_FILL   = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              req_seen_q, req_seen_d;
    logic [ADDR_W-1:1] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              ack_q, ack_d;
    logic              sreq_q, sreq_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic              fflush_q, fflush_d;
    logic              ram_we;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [63:0]       line_mem [LINES];
    logic [TAG_W-1:0]  rd_tag_q;
    logic [63:0]       rd_line_q;

    logic [IDX_W-1:0]  idx_in, idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic [1:0]        word_q;
    logic              hit, sdr_done;
    logic              unused_addr_bit;

    assign idx_in          = client_addr[3+IDX_W-1:3];
    assign idx_q           = addr_q[3+IDX_W-1:3];
    assign tag_q           = addr_q[ADDR_W-1:3+IDX_W];
    assign word_q          = addr_q[2:1];
    assign unused_addr_bit = client_addr[0];

    // A flush in the lookup cycle forces a miss even if the line looked valid.
    assign hit      = valid_q[idx_q] && (rd_tag_q == tag_q) && !flush;
    assign sdr_done = (sdr_ack == sreq_q);

    always_comb begin
        state_d    = state_q;
        req_seen_d = req_seen_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ack_d      = ack_q;
        sreq_d     = sreq_q;
        saddr_d    = saddr_q;
        valid_d    = valid_q;
        fflush_d   = fflush_q;
        ram_we     = 1'b0;
        if (flush) begin
            valid_d = '0;
        end
        case (state_q)
            S_IDLE: begin
                if (client_req != req_seen_q) begin
                    addr_d     = client_addr[ADDR_W-1:1];
                    req_seen_d = client_req;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    data_d  = rd_line_q[{word_q, 4'b0000} +: 16];
                    ack_d   = req_seen_q;
                    state_d = S_IDLE;
                end else begin
                    saddr_d  = {tag_q, idx_q, 3'b000};
                    sreq_d   = ~sreq_q;
                    fflush_d = 1'b0;
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                if (flush) begin
                    fflush_d = 1'b1;
                end
                if (sdr_done) begin
                    ram_we = 1'b1;
                    // A flush seen at any point of the refill keeps the new line invalid.
                    if (!fflush_q && !flush) begin
                        valid_d[idx_q] = 1'b1;
                    end
                    data_d  = sdr_data[{word_q, 4'b0000} +: 16];
                    ack_d   = req_seen_q;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (sdr_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (sreq_q != sdr_ack) ? S_DRAIN : S_IDLE;
            req_seen_q <= client_req;
            addr_q     <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            valid_q    <= '0;
            fflush_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_seen_q <= req_seen_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            fflush_q   <= fflush_d;
        end
    end

    // The SDRAM handshake survives reset so an in-flight burst can be drained cleanly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sreq_q  <= sreq_d;
            saddr_q <= saddr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            tag_mem[idx_q]  <= tag_q;
            line_mem[idx_q] <= sdr_data;
        end
        rd_tag_q  <= tag_mem[idx_in];
        rd_line_q <= line_mem[idx_in];
    end

    assign client_data = data_q;
    assign client_ack  = ack_q;
    assign sdr_addr    = saddr_q;
    assign sdr_req     = sreq_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pivot_rom_cache.sv
// Randomised bench for pivot_rom_cache: a scoreboard fed by the stimulus, a monitor on the
// client ack toggle, and an SDRAM responder with programmable latency.
module tb_pivot_rom_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [26:0] client_addr;
    logic        client_req;
    logic [15:0] client_data;
    logic        client_ack;
    logic [26:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_ack;
    logic [63:0] sdr_data;
    logic        busy;

    pivot_rom_cache #(.IDX_W(6), .ADDR_W(27)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .client_addr(client_addr), .client_req(client_req),
        .client_data(client_data), .client_ack(client_ack),
        .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack),
        .sdr_data(sdr_data), .busy(busy)
    );

    typedef struct {
        logic [15:0] data;
        logic        ack;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fetch_cnt = 0;
    int          ack_count = 0;
    int          ack_cyc = 0;
    int          sdr_delay = 0;
    int          sdr_ack_cycs[$];
    logic [26:0] last_sdr_addr = '0;
    bit          model_valid[64];
    logic [26:0] model_line[64];

    initial forever begin
        #5 clk = 1'b1;
        cyc++;
        #5 clk = 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Backing-store contents: one fixed pattern line, every other line a function of its address.
    function automatic logic [63:0] line_data(input logic [26:0] a);
        logic [63:0] r;
        logic [23:0] ln;
        ln = a[26:3];
        if ({a[26:3], 3'b000} == 27'h0100000) return 64'h4444_3333_2222_1111;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'(ln * 24'd5 + 24'(k) * 24'h3A1 + 24'h55);
        return r;
    endfunction

    function automatic logic [15:0] word_of(input logic [26:0] a);
        logic [63:0] d;
        d = line_data(a);
        return 16'(d >> (32'(a[2:1]) * 16));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    // SDRAM responder: answers each new sdr_req toggle after sdr_delay cycles.
    initial begin
        bit pend;
        int cnt;
        pend = 1'b0;
        cnt = 0;
        sdr_ack = 1'b0;
        sdr_data = '0;
        #1 sdr_ack = sdr_req;
        forever begin
            @(posedge clk);
            #1;
            if (sdr_req != sdr_ack) begin
                if (!pend) begin
                    pend = 1'b1;
                    cnt = sdr_delay;
                    fetch_cnt++;
                    last_sdr_addr = sdr_addr;
                end else begin
                    cnt--;
                end
                if (cnt <= 0) begin
                    sdr_data = line_data(sdr_addr);
                    sdr_ack = sdr_req;
                    pend = 1'b0;
                    sdr_ack_cycs.push_back(cyc);
                end
            end
        end
    end

    // Monitor: every client_ack toggle retires one scoreboard entry.
    initial begin
        logic ack_prev;
        exp_t e;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ack_prev = 1'b0;
            end else if (client_ack != ack_prev) begin
                ack_prev = client_ack;
                ack_count++;
                ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 64'(client_ack), 64'(~client_ack));
                end else begin
                    e = exp_q.pop_front();
                    chk("client_data", 64'(client_data), 64'(e.data));
                    chk("client_ack", 64'(client_ack), 64'(e.ack));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        wait_cycles(1);
        flush = 1'b0;
        clear_model();
    endtask

    // fmode: 0 plain, 1 flush together with the request, 2 flush while the line is being fetched.
    task automatic do_req(input logic [26:0] addr, input int fmode_in);
        logic [26:0] line;
        int   idx, f0, a0, c0, lat_exp, n, fmode;
        bit   miss, flushed;
        exp_t e;
        fmode = fmode_in;
        line  = {addr[26:3], 3'b000};
        idx   = int'(addr[8:3]);
        if (fmode == 1) clear_model();
        miss = !model_valid[idx] || (model_line[idx] != line);
        if (!miss && fmode == 2) fmode = 0;
        if (fmode == 2 && sdr_delay == 0) sdr_delay = 1;
        f0 = fetch_cnt;
        a0 = ack_count;
        client_addr = addr;
        client_req  = ~client_req;
        if (fmode == 1) flush = 1'b1;
        c0 = cyc;
        lat_exp = miss ? 3 + sdr_delay : 2;
        e.data = word_of(addr);
        e.ack  = client_req;
        exp_q.push_back(e);
        flushed = 1'b0;
        n = 0;
        while (ack_count == a0 && n < 80) begin
            wait_cycles(1);
            n++;
            flush = 1'b0;
            if (fmode == 2 && !flushed && fetch_cnt != f0) begin
                flush = 1'b1;
                flushed = 1'b1;
            end
        end
        flush = 1'b0;
        if (ack_count == a0) begin
            chk("ack_timeout", 64'(n), 64'(0));
            exp_q.delete();
        end else begin
            chk("latency", 64'(ack_cyc - c0), 64'(lat_exp));
            chk("fetches", 64'(fetch_cnt - f0), 64'(miss));
            if (miss) chk("sdr_addr", 64'(last_sdr_addr), 64'(line));
        end
        if (fmode == 2) begin
            clear_model();
        end else if (miss) begin
            model_valid[idx] = 1'b1;
            model_line[idx]  = line;
        end
        $display("txn addr=%07h mode=%0d miss=%0d data=%04h lat=%0d", addr, fmode, miss, e.data, ack_cyc - c0);
    endtask

    initial begin
        logic [26:0] a;
        int f0, a0, n, fm;
        exp_t e;
        reset = 1'b1;
        flush = 1'b0;
        client_addr = '0;
        client_req = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_ack", 64'(client_ack), 64'(0));
        chk("reset_data", 64'(client_data), 64'(0));

        do_req(27'h0100002, 0);
        do_req(27'h0100006, 0);
        do_req(27'h0100200, 0);
        do_req(27'h0100002, 0);
        flush_pulse();
        do_req(27'h0100002, 0);
        do_req(27'h0100004, 0);
        sdr_delay = 2;
        do_req(27'h0100208, 2);
        do_req(27'h0100208, 0);
        do_req(27'h010020A, 1);

        // Reset during a refill: the burst must be drained before any new request is served.
        if (client_req == 1'b0) do_req(27'h0200010, 0);
        flush_pulse();
        sdr_delay = 7;
        f0 = fetch_cnt;
        client_addr = 27'h7FFFFF8;
        client_req = ~client_req;
        n = 0;
        while (fetch_cnt == f0 && n < 20) begin
            wait_cycles(1);
            n++;
        end
        chk("drain_fetch_started", 64'(fetch_cnt - f0), 64'(1));
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        sdr_delay = 0;
        clear_model();
        chk("drain_busy", 64'(busy), 64'(1));
        chk("drain_ack_reset", 64'(client_ack), 64'(0));
        a0 = ack_count;
        client_addr = 27'h0100004;
        client_req = ~client_req;
        e.data = word_of(27'h0100004);
        e.ack = client_req;
        exp_q.push_back(e);
        n = 0;
        while (ack_count == a0 && n < 60) begin
            wait_cycles(1);
            n++;
        end
        chk("drain_served", 64'(ack_count - a0), 64'(1));
        chk("drain_fetches", 64'(fetch_cnt - f0), 64'(2));
        if (sdr_ack_cycs.size() > f0) chk("drain_ack_cycle", 64'(ack_cyc), 64'(sdr_ack_cycs[f0] + 4));
        model_valid[0] = 1'b1;
        model_line[0]  = 27'h0100000;
        $display("txn addr=%07h drained then served data=%04h", 27'h0100004, e.data);

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 2))
                0: a = {18'h00000, 9'h000};
                1: a = {18'h00001, 9'h000};
                default: a = {18'h3FFFF, 9'h000};
            endcase
            a[8:3] = 6'($urandom_range(0, 3));
            a[2:0] = 3'($urandom_range(0, 7));
            fm = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
            sdr_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) flush_pulse();
            wait_cycles($urandom_range(0, 2));
            do_req(a, fm);
        end

        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        chk("final_reset_busy", 64'(busy), 64'(0));
        chk("final_reset_ack", 64'(client_ack), 64'(0));
        chk("final_reset_data", 64'(client_data), 64'(0));
        wait_cycles(3);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pivot_rom_cache.md
Name: pivot_rom_cache

Overview:
Read-only line cache between the pivot layer's 16-bit toggle-handshake ROM port and one 64-bit SDRAM burst channel. It returns hits within 2 clocks, so a pivot pixel fetch normally completes inside one pixel period. Misses fetch one 4-word line from SDRAM, refill the cache, then answer the client. It instantiates alongside the pivot chip in the F2 top level and removes most pivot traffic from the shared SDRAM arbiter.

Parameters:
IDX_W, 6, index bits; number of lines = 2**IDX_W, each line 4 x 16-bit words (8 bytes)
ADDR_W, 27, byte address width on both sides

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
flush  in  1  one-cycle pulse; invalidates all lines
client_addr  in  ADDR_W  byte address of requested word; bit 0 ignored
client_req  in  1  toggle; a change versus the last accepted value is a new request
client_data  out  16  returned word
client_ack  out  1  toggle; set equal to client_req when client_data is valid
sdr_addr  out  ADDR_W  line address, bits [2:0] forced to 0
sdr_req  out  1  toggle; a change starts a 64-bit burst read
sdr_ack  in  1  toggle; sdr_ack==sdr_req means sdr_data is valid (same cycle)
sdr_data  in  64  line; [15:0]=word 0 (addr[2:1]=0) ... [63:48]=word 3
busy  out  1  high in LOOKUP/FILL/DRAIN

Behaviour:
- Address split: word = addr[2:1]; index = addr[3+IDX_W-1:3]; tag = addr[ADDR_W-1:3+IDX_W].
- Storage: tag+data in synchronous-read RAM. Valid bits are flops, cleared in a single cycle.
- Reset values:
  - state=IDLE, client_ack=0, client_data=0, busy=0, all valid=0.
  - req_seen<=client_req, so no spurious request is taken after reset.
  - sdr_req and sdr_addr hold their current values (not reset).
  - If sdr_req!=sdr_ack at reset, the next state is DRAIN instead of IDLE.
- IDLE:
  - When client_req!=req_seen: latch addr, set req_seen<=client_req, issue RAM read at index, go LOOKUP.
- LOOKUP (1 cycle): compare tag and valid.
  - Hit: client_data<=selected word, client_ack<=req_seen, go IDLE. Hit latency is 2 clocks from the req edge to the ack toggle.
  - Miss: sdr_addr<={tag,index,3'b0}, sdr_req<=~sdr_req, go FILL.
- FILL: wait for sdr_ack==sdr_req. Then, in that same cycle:
  - write tag and data to RAM;
  - set valid[index] unless a flush occurred during FILL;
  - client_data<=sdr_data word [addr[2:1]], client_ack<=req_seen, go IDLE.
- DRAIN: wait for sdr_ack==sdr_req, discard the data, go IDLE.
- One outstanding client request only. A req toggle arriving outside IDLE is detected on return to IDLE, so a new request in flight is never lost. Client contract: no second toggle before ack.
- flush:
  - In IDLE or LOOKUP it clears all valid bits. A LOOKUP in the flush cycle treats the access as a miss.
  - A flush coinciding with a new request in IDLE is applied first, so the request misses.
  - A flush during FILL leaves the refilled line invalid; the client is still served.
- The same-index line is overwritten on refill (direct mapped, no replacement policy).
- Addresses wrap at 2**ADDR_W; there are no range checks.

Test Plan:
- Reset, then toggle client_req with addr 0x0100002 on a cold cache -> sdr_req toggles with sdr_addr=0x0100000. Return sdr_data=0x4444_3333_2222_1111 -> client_data=0x2222, client_ack toggles the cycle the ack is seen.
- Same line, addr 0x0100006 -> no sdr_req toggle; client_data=0x4444 with ack exactly 2 clocks after the req edge.
- Conflict: addr 0x0100200 (same index, different tag, IDX_W=6) -> miss and refill. Re-reading 0x0100002 -> miss again.
- Pulse flush after the line is cached, then re-read 0x0100002 -> miss. Flush during a FILL -> the client is served, and an immediate re-read misses.
- Assert reset while in FILL, with sdr_ack returned 5 clocks later -> block in DRAIN. A client req toggled during DRAIN is not served until the drain completes, then proceeds as a miss.
- Back-to-back: a client toggle one cycle after ack -> accepted. With sdr_ack held equal to sdr_req at reset -> state IDLE directly and client_ack=0.
